// File: rtl/dsi_packet_assembler_pkg.sv
// DSI packet assembler shared types: FSM encoding, byte counts, data types.
// Latched request header and checksum byte selection helper.
package dsi_packet_assembler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_GAP
  } state_t;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned CRC_BYTES = 2;

  localparam logic [5:0] DT_DCS_SHORT_WR0 = 6'h05;
  localparam logic [5:0] DT_DCS_SHORT_WR1 = 6'h15;
  localparam logic [5:0] DT_GEN_LONG_WR   = 6'h29;
  localparam logic [5:0] DT_DCS_LONG_WR   = 6'h39;

  typedef struct packed {
    logic        long_pkt;
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
  } pkt_hdr_t;

  function automatic logic [7:0] crc_byte(
    input logic [15:0] crc,
    input logic [1:0]  idx
  );
    return idx[0] ? crc[15:8] : crc[7:0];
  endfunction

endpackage

// File: rtl/dsi_crc.sv
// DSI CRC-16 (poly 0x1021 reflected, init 0xFFFF), LSB-first per byte.
// Processes up to g_max_data_bytes bytes per valid cycle; sync reset.
module dsi_crc #(
  parameter int unsigned g_max_data_bytes = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic [3:0]                    nbytes_i,
  input  logic [8*g_max_data_bytes-1:0] data_i,
  output logic [15:0]                   crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_nx;

  always_comb begin
    crc_nx = crc_q;
    for (int b = 0; b < int'(g_max_data_bytes); b++) begin
      if (b < int'(nbytes_i)) begin
        for (int i = 0; i < 8; i++) begin
          crc_nx = (crc_nx >> 1)
                 ^ ((crc_nx[0] ^ data_i[8*b+i]) ? 16'h8408 : 16'h0000);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= 16'hFFFF;
    end else if (valid_i) begin
      crc_q <= crc_nx;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/dsi_parity.sv
// DSI 6-bit Hamming ECC over the 24-bit packet header.
// Bit 0 of data_i is DI bit 0; ecc_o[7:6] are always zero.
module dsi_parity (
  input  logic [23:0] data_i,
  output logic [7:0]  ecc_o
);

  logic [23:0] d;
  assign d = data_i;

  assign ecc_o[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10]
                  ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
  assign ecc_o[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10]
                  ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
  assign ecc_o[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11]
                  ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
  assign ecc_o[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13]
                  ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
  assign ecc_o[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16]
                  ^ d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
  assign ecc_o[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16]
                  ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
  assign ecc_o[7:6] = 2'b00;

endmodule

// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: header+ECC, payload, CRC into one registered byte stream.
// Build option DSI_PACKET_ASSEMBLER_CRC_EN enables CRC; otherwise checksum is 0x0000.
module dsi_packet_assembler
  import dsi_packet_assembler_pkg::*;
#(
  parameter int unsigned g_idle_gap = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        long_i,
  input  logic [5:0]  dt_i,
  input  logic [1:0]  vc_i,
  input  logic [15:0] wc_i,
  output logic        busy_o,
  input  logic [7:0]  pl_data_i,
  input  logic        pl_valid_i,
  output logic        pl_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_sop_o,
  output logic        out_eop_o
);

  localparam logic [3:0] GAP_INIT = 4'(g_idle_gap);
  localparam logic [1:0] HDR_LAST = 2'(HDR_BYTES - 1);
  localparam logic [1:0] CRC_LAST = 2'(CRC_BYTES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  pkt_hdr_t    hdr_q, hdr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;

  logic        adv;
  logic        drain;
  logic        pl_take;
  logic [7:0]  di;
  logic [7:0]  ecc;
  logic [7:0]  hbyte;
  logic [15:0] crc;
  state_t      end_st;

  assign adv   = !valid_q || out_ready_i;
  assign drain = valid_q && eop_q;
  assign di    = {hdr_q.vc, hdr_q.dt};

  assign pl_ready_o = (state_q == ST_PAYLOAD) && (rem_q != 16'd0)
                    && adv && !rst_i;
  assign pl_take    = pl_valid_i && pl_ready_o;

  dsi_parity u_parity (
    .data_i ({hdr_q.wc, di}),
    .ecc_o  (ecc)
  );

`ifdef DSI_PACKET_ASSEMBLER_CRC_EN
  logic crc_clr;
  assign crc_clr = rst_i || ((state_q == ST_IDLE) && req_i);

  dsi_crc #(
    .g_max_data_bytes (1)
  ) u_crc (
    .clk_i    (clk_i),
    .rst_i    (crc_clr),
    .valid_i  (pl_take),
    .nbytes_i (4'd1),
    .data_i   (pl_data_i),
    .crc_o    (crc)
  );
`else
  assign crc = 16'h0000;
`endif

  always_comb begin
    hbyte = di;
    unique case (idx_q)
      2'd0:    hbyte = di;
      2'd1:    hbyte = hdr_q.wc[7:0];
      2'd2:    hbyte = hdr_q.wc[15:8];
      default: hbyte = ecc;
    endcase
  end

  assign end_st = (GAP_INIT == 4'd0) ? ST_IDLE : ST_GAP;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    // An accepted (or empty) slot clears unless refilled below
    if (adv) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          hdr_d   = '{long_pkt: long_i, dt: dt_i, vc: vc_i, wc: wc_i};
          rem_d   = wc_i;
          idx_d   = 2'd0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (drain) begin
          if (out_ready_i) begin
            state_d = end_st;
            gap_d   = GAP_INIT;
          end
        end else if (adv) begin
          valid_d = 1'b1;
          data_d  = hbyte;
          sop_d   = (idx_q == 2'd0);
          eop_d   = (idx_q == HDR_LAST) && !hdr_q.long_pkt;
          if (idx_q != HDR_LAST) begin
            idx_d = idx_q + 2'd1;
          end else if (hdr_q.long_pkt) begin
            idx_d   = 2'd0;
            state_d = (rem_q == 16'd0) ? ST_CRC : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pl_take) begin
          valid_d = 1'b1;
          data_d  = pl_data_i;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            idx_d   = 2'd0;
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (drain) begin
          if (out_ready_i) begin
            state_d = end_st;
            gap_d   = GAP_INIT;
          end
        end else if (adv) begin
          valid_d = 1'b1;
          data_d  = crc_byte(crc, idx_q);
          eop_d   = (idx_q == CRC_LAST);
          idx_d   = CRC_LAST;
        end
      end
      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      rem_q   <= 16'd0;
      gap_q   <= 4'd0;
      hdr_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_sop_o   = sop_q;
  assign out_eop_o   = eop_q;

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Randomized self-checking bench for dsi_packet_assembler (idle gap = 3).
// Expected streams come from a table-based ECC/CRC model of the DSI packet format.
module tb_dsi_packet_assembler;
  import dsi_packet_assembler_pkg::*;

  localparam int GAP = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        long_i;
  logic [5:0]  dt_i;
  logic [1:0]  vc_i;
  logic [15:0] wc_i;
  logic        busy_o;
  logic [7:0]  pl_data_i;
  logic        pl_valid_i;
  logic        pl_ready_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_sop_o;
  logic        out_eop_o;

  int checks   = 0;
  int failures = 0;

  logic [5:0]  syn_tab [24];
  logic [15:0] crc_tab [256];
  logic [7:0]  pl_q [$];
  logic [9:0]  last_got [$];

  always #5 clk_i = ~clk_i;

  dsi_packet_assembler #(
    .g_idle_gap (GAP)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .long_i      (long_i),
    .dt_i        (dt_i),
    .vc_i        (vc_i),
    .wc_i        (wc_i),
    .busy_o      (busy_o),
    .pl_data_i   (pl_data_i),
    .pl_valid_i  (pl_valid_i),
    .pl_ready_o  (pl_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sop_o   (out_sop_o),
    .out_eop_o   (out_eop_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [5:0] s = 6'd0;
    for (int i = 0; i < 24; i++) if (d[i]) s ^= syn_tab[i];
    return {2'b00, s};
  endfunction

  function automatic logic [15:0] crc_model(input logic [7:0] b [$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) c = (c >> 8) ^ crc_tab[(c[7:0] ^ b[i])];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Caller must be at a cycle start (1 time unit after a rising edge)
  task automatic run_pkt(input bit lng, input logic [5:0] dt,
                         input logic [1:0] vc, input logic [15:0] wc,
                         input bit rnd);
    logic [7:0] exp_q [$];
    logic [9:0] got_q [$];
    logic [7:0] di;
    logic [15:0] crc;
    bit req_done = 0;
    bit eop_seen = 0;
    int cyc = 0, start_cyc = 0, eop_cyc = 0, pl_i = 0;
    int n;
    di = {vc, dt};
    if (lng) while (pl_q.size() < int'(wc)) pl_q.push_back(8'($urandom));
    exp_q.push_back(di);
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(ecc_model({wc, di}));
    if (lng) begin
      foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
`ifdef DSI_PACKET_ASSEMBLER_CRC_EN
      crc = crc_model(pl_q);
`else
      crc = 16'h0000;
`endif
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
    while (cyc < 2000) begin
      if (!req_done) begin
        if (!busy_o) begin
          req_i = 1; long_i = lng; dt_i = dt; vc_i = vc; wc_i = wc;
          req_done = 1;
          start_cyc = cyc;
        end else begin
          req_i = 0;
        end
      end else if (eop_seen && !busy_o) begin
        break;
      end else begin
        if (cyc == start_cyc + 1) chk("busy_rise", 32'(busy_o), 1);
        req_i  = rnd ? 1'($urandom) : 1'b0;
        long_i = 1'($urandom);
        dt_i   = 6'($urandom);
        vc_i   = 2'($urandom);
        wc_i   = 16'($urandom);
      end
      out_ready_i = rnd ? ($urandom % 4 != 0) : 1'b1;
      pl_valid_i  = rnd ? ($urandom % 3 != 0) : 1'b1;
      pl_data_i   = (pl_i < pl_q.size()) ? pl_q[pl_i] : 8'($urandom);
      #1;
      if (out_valid_o && out_ready_i) begin
        got_q.push_back({out_sop_o, out_eop_o, out_data_o});
        if (out_eop_o && !eop_seen) begin
          eop_seen = 1;
          eop_cyc  = cyc;
        end
      end
      if (pl_valid_i && pl_ready_o) pl_i++;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("pkt_timeout", 32'(cyc < 2000), 1);
    chk("pkt_len", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("byte%0d", i), 32'(got_q[i]),
          32'({(i == 0), (i == exp_q.size() - 1), exp_q[i]}));
    end
    chk("pl_used", 32'(pl_i), 32'(pl_q.size()));
    chk("gap_len", 32'(cyc - eop_cyc), 32'(GAP + 1));
    last_got = got_q;
    pl_q.delete();
  endtask

  initial begin
    int cons;
    int k;
    syn_tab = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    for (int n = 0; n < 256; n++) begin
      logic [15:0] c = 16'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tab[n] = c;
    end

    rst_i = 1; req_i = 0; long_i = 0; dt_i = 0; vc_i = 0; wc_i = 0;
    pl_data_i = 0; pl_valid_i = 1; out_ready_i = 1;
    repeat (3) tick();
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_sop",   32'(out_sop_o), 0);
    chk("rst_eop",   32'(out_eop_o), 0);
    chk("rst_data",  32'(out_data_o), 0);
    chk("rst_plrdy", 32'(pl_ready_o), 0);
    rst_i = 0;
    tick();

    run_pkt(0, DT_DCS_SHORT_WR0, 2'd0, 16'h0011, 0);
    if (last_got.size() == 4) chk("short_ecc", 32'(last_got[3][7:0]), 32'h36);
    else chk("short_ecc_len", 32'(last_got.size()), 4);

    run_pkt(1, DT_DCS_LONG_WR, 2'd0, 16'h0000, 0);
    if (last_got.size() == 6) begin
`ifdef DSI_PACKET_ASSEMBLER_CRC_EN
      chk("wc0_crc", 32'({last_got[4][7:0], last_got[5][7:0]}), 32'hFFFF);
`else
      chk("wc0_crc", 32'({last_got[4][7:0], last_got[5][7:0]}), 32'h0000);
`endif
    end else chk("wc0_len", 32'(last_got.size()), 6);

    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_pkt(1, DT_DCS_LONG_WR, 2'd1, 16'd4, 1);

    for (int p = 0; p < 24; p++) begin
      run_pkt(1'($urandom), 6'($urandom), 2'($urandom),
              16'($urandom_range(0, 20)), 1'($urandom));
    end

    // Reset while the third payload byte is on offer
    req_i = 1; long_i = 1; dt_i = DT_DCS_LONG_WR; vc_i = 1; wc_i = 16'd8;
    out_ready_i = 1; pl_valid_i = 1;
    cons = 0;
    k = 0;
    while (k < 100 && cons < 2) begin
      pl_data_i = 8'($urandom);
      #1;
      if (pl_valid_i && pl_ready_o) cons++;
      tick();
      req_i = 0;
      k++;
    end
    chk("rst_mid_reach", 32'(cons), 2);
    rst_i = 1;
    #1;
    chk("rst_mid_plrdy", 32'(pl_ready_o), 0);
    tick();
    rst_i = 0;
    chk("rst_mid_valid", 32'(out_valid_o), 0);
    chk("rst_mid_busy",  32'(busy_o), 0);
    chk("rst_mid_plrdy2", 32'(pl_ready_o), 0);
    run_pkt(1, DT_DCS_LONG_WR, 2'd2, 16'd5, 1);
    req_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
